// File: rtl/spu_register_file_if.sv
//------------------------------------------------------------------------------
// spu_register_file_if
// Bundles the read-address, writeback-packet, and read-data/addr_q signals of
// the SPU register file.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spu_register_file_if #(
  parameter int UNIT_ID_SIZE   = 3,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int QUADWORD       = 128,
  parameter int PKT_W          = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH + QUADWORD
);
  logic [REG_ADDR_WIDTH-1:0] rf_addr_ra_rd_even;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rb_rd_even;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rc_rd_even;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_ra_rd_odd;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rb_rd_odd;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rc_rd_odd;

  // Packets are MSB-first: index 0 is the top bit of the unit-ID field.
  logic [0:PKT_W-1]          wb_even_pkt;
  logic [0:PKT_W-1]          wb_odd_pkt;

  logic [QUADWORD-1:0]       ra_rd_even;
  logic [QUADWORD-1:0]       rb_rd_even;
  logic [QUADWORD-1:0]       rc_rd_even;
  logic [QUADWORD-1:0]       ra_rd_odd;
  logic [QUADWORD-1:0]       rb_rd_odd;
  logic [QUADWORD-1:0]       rc_rd_odd;

  logic [REG_ADDR_WIDTH-1:0] rf_addr_ra_rd_even_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rb_rd_even_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rc_rd_even_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_ra_rd_odd_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rb_rd_odd_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_rc_rd_odd_q;

  modport master (
    output rf_addr_ra_rd_even, rf_addr_rb_rd_even, rf_addr_rc_rd_even,
    output rf_addr_ra_rd_odd,  rf_addr_rb_rd_odd,  rf_addr_rc_rd_odd,
    output wb_even_pkt, wb_odd_pkt,
    input  ra_rd_even, rb_rd_even, rc_rd_even,
    input  ra_rd_odd,  rb_rd_odd,  rc_rd_odd,
    input  rf_addr_ra_rd_even_q, rf_addr_rb_rd_even_q, rf_addr_rc_rd_even_q,
    input  rf_addr_ra_rd_odd_q,  rf_addr_rb_rd_odd_q,  rf_addr_rc_rd_odd_q
  );

  modport slave (
    input  rf_addr_ra_rd_even, rf_addr_rb_rd_even, rf_addr_rc_rd_even,
    input  rf_addr_ra_rd_odd,  rf_addr_rb_rd_odd,  rf_addr_rc_rd_odd,
    input  wb_even_pkt, wb_odd_pkt,
    output ra_rd_even, rb_rd_even, rc_rd_even,
    output ra_rd_odd,  rb_rd_odd,  rc_rd_odd,
    output rf_addr_ra_rd_even_q, rf_addr_rb_rd_even_q, rf_addr_rc_rd_even_q,
    output rf_addr_ra_rd_odd_q,  rf_addr_rb_rd_odd_q,  rf_addr_rc_rd_odd_q
  );
endinterface

`default_nettype wire

// File: rtl/spu_register_file.sv
//------------------------------------------------------------------------------
// spu_register_file
// 128 x 128-bit dual-issue SPU register file: six registered read ports, two
// writeback ports, same-cycle write-to-read bypass.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spu_register_file #(
  parameter int UNIT_ID_SIZE   = 3,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int QUADWORD       = 128,
  parameter int NUM_REGS       = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  spu_register_file_if.slave   rf
);
  localparam int C_NUM_PORTS = 6;
  localparam int C_WE_BIT    = UNIT_ID_SIZE;
  localparam int C_ADDR_LSB  = UNIT_ID_SIZE + 1;
  localparam int C_DATA_LSB  = UNIT_ID_SIZE + 1 + REG_ADDR_WIDTH;

  logic [QUADWORD-1:0]       r_regs    [NUM_REGS];
  logic [QUADWORD-1:0]       r_rd_data [C_NUM_PORTS];
  logic [REG_ADDR_WIDTH-1:0] r_rd_addr [C_NUM_PORTS];
  logic [REG_ADDR_WIDTH-1:0] w_rd_addr [C_NUM_PORTS];
  logic [QUADWORD-1:0]       w_rd_next [C_NUM_PORTS];

  logic                      w_even_we;
  logic [REG_ADDR_WIDTH-1:0] w_even_addr;
  logic [QUADWORD-1:0]       w_even_data;
  logic                      w_odd_we;
  logic [REG_ADDR_WIDTH-1:0] w_odd_addr;
  logic [QUADWORD-1:0]       w_odd_data;
  logic [2*UNIT_ID_SIZE-1:0] w_unused_unit_id;

  assign w_even_we        = rf.wb_even_pkt[C_WE_BIT];
  assign w_even_addr      = rf.wb_even_pkt[C_ADDR_LSB +: REG_ADDR_WIDTH];
  assign w_even_data      = rf.wb_even_pkt[C_DATA_LSB +: QUADWORD];
  assign w_odd_we         = rf.wb_odd_pkt[C_WE_BIT];
  assign w_odd_addr       = rf.wb_odd_pkt[C_ADDR_LSB +: REG_ADDR_WIDTH];
  assign w_odd_data       = rf.wb_odd_pkt[C_DATA_LSB +: QUADWORD];
  assign w_unused_unit_id = {rf.wb_even_pkt[0 +: UNIT_ID_SIZE],
                             rf.wb_odd_pkt[0 +: UNIT_ID_SIZE]};

  assign w_rd_addr[0] = rf.rf_addr_ra_rd_even;
  assign w_rd_addr[1] = rf.rf_addr_rb_rd_even;
  assign w_rd_addr[2] = rf.rf_addr_rc_rd_even;
  assign w_rd_addr[3] = rf.rf_addr_ra_rd_odd;
  assign w_rd_addr[4] = rf.rf_addr_rb_rd_odd;
  assign w_rd_addr[5] = rf.rf_addr_rc_rd_odd;

  // Odd slot carries the younger instruction, so it wins both the array
  // write and the bypass when both packets target the same register.
  for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_port
    assign w_rd_next[p] = (w_odd_we  && (w_odd_addr  == w_rd_addr[p])) ? w_odd_data  :
                          (w_even_we && (w_even_addr == w_rd_addr[p])) ? w_even_data :
                          r_regs[w_rd_addr[p]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_even_we) begin
        r_regs[w_even_addr] <= w_even_data;
      end
      if (w_odd_we) begin
        r_regs[w_odd_addr] <= w_odd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        r_rd_data[p] <= '0;
        r_rd_addr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < C_NUM_PORTS; p++) begin
        r_rd_data[p] <= w_rd_next[p];
        r_rd_addr[p] <= w_rd_addr[p];
      end
    end
  end

  assign rf.ra_rd_even = r_rd_data[0];
  assign rf.rb_rd_even = r_rd_data[1];
  assign rf.rc_rd_even = r_rd_data[2];
  assign rf.ra_rd_odd  = r_rd_data[3];
  assign rf.rb_rd_odd  = r_rd_data[4];
  assign rf.rc_rd_odd  = r_rd_data[5];

  assign rf.rf_addr_ra_rd_even_q = r_rd_addr[0];
  assign rf.rf_addr_rb_rd_even_q = r_rd_addr[1];
  assign rf.rf_addr_rc_rd_even_q = r_rd_addr[2];
  assign rf.rf_addr_ra_rd_odd_q  = r_rd_addr[3];
  assign rf.rf_addr_rb_rd_odd_q  = r_rd_addr[4];
  assign rf.rf_addr_rc_rd_odd_q  = r_rd_addr[5];
endmodule

`default_nettype wire

// File: tb/tb_spu_register_file.sv
//------------------------------------------------------------------------------
// tb_spu_register_file
// Directed self-checking bench for spu_register_file.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spu_register_file;
  localparam int PKT_W = 139;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  spu_register_file_if rf_if ();

  spu_register_file dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port order everywhere: ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd.
  logic [127:0] rd [6];
  logic [6:0]   aq [6];
  assign rd[0] = rf_if.ra_rd_even;
  assign rd[1] = rf_if.rb_rd_even;
  assign rd[2] = rf_if.rc_rd_even;
  assign rd[3] = rf_if.ra_rd_odd;
  assign rd[4] = rf_if.rb_rd_odd;
  assign rd[5] = rf_if.rc_rd_odd;
  assign aq[0] = rf_if.rf_addr_ra_rd_even_q;
  assign aq[1] = rf_if.rf_addr_rb_rd_even_q;
  assign aq[2] = rf_if.rf_addr_rc_rd_even_q;
  assign aq[3] = rf_if.rf_addr_ra_rd_odd_q;
  assign aq[4] = rf_if.rf_addr_rb_rd_odd_q;
  assign aq[5] = rf_if.rf_addr_rc_rd_odd_q;

  function automatic logic [0:PKT_W-1] mkpkt(input logic we, input logic [6:0] a,
                                             input logic [127:0] d);
    return {3'b101, we, a, d};
  endfunction

  // WE=0 packet with junk fields: must never touch the array or bypass.
  function automatic logic [0:PKT_W-1] idle_pkt();
    return {3'b111, 1'b0, 7'h7F, {4{32'hDEADBEEF}}};
  endfunction

  task automatic set_addrs(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                           input logic [6:0] a3, input logic [6:0] a4, input logic [6:0] a5);
    rf_if.rf_addr_ra_rd_even = a0;
    rf_if.rf_addr_rb_rd_even = a1;
    rf_if.rf_addr_rc_rd_even = a2;
    rf_if.rf_addr_ra_rd_odd  = a3;
    rf_if.rf_addr_rb_rd_odd  = a4;
    rf_if.rf_addr_rc_rd_odd  = a5;
  endtask

  task automatic set_pkts(input logic [0:PKT_W-1] ev, input logic [0:PKT_W-1] od);
    rf_if.wb_even_pkt = ev;
    rf_if.wb_odd_pkt  = od;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_pkts(idle_pkt(), idle_pkt());
    set_addrs(7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6);
    #1 reset = 1'b0;
    #1;
    for (int p = 0; p < 6; p++) begin
      total++;
      if (rd[p] !== 128'h0) begin
        bad++;
        $display("FAIL reset_data[%0d] got=%h want=0", p, rd[p]);
      end
      total++;
      if (aq[p] !== 7'h0) begin
        bad++;
        $display("FAIL reset_addr_q[%0d] got=%h want=0", p, aq[p]);
      end
    end
    // Write during reset must be discarded; outputs stay cleared.
    set_pkts(mkpkt(1'b1, 7'd10, 128'hCAFE), idle_pkt());
    set_addrs(7'd10, 7'd10, 7'd10, 7'd10, 7'd10, 7'd10);
    step();
    total++;
    if (rd[0] !== 128'h0 || aq[0] !== 7'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h/%h want=0/0", rd[0], aq[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    set_pkts(idle_pkt(), idle_pkt());
    step();
    total++;
    if (rd[0] !== 128'h0) begin
      bad++;
      $display("FAIL reset_write_discarded got=%h want=0", rd[0]);
    end
    total++;
    if (aq[0] !== 7'd10) begin
      bad++;
      $display("FAIL reset_first_addr_q got=%h want=0a", aq[0]);
    end
  endtask

  task automatic test_write_read();
    set_pkts(mkpkt(1'b1, 7'd5, {16{8'hA5}}), idle_pkt());
    set_addrs(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    step();
    set_pkts(idle_pkt(), idle_pkt());
    set_addrs(7'd5, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    step();
    total++;
    if (rd[0] !== {16{8'hA5}}) begin
      bad++;
      $display("FAIL t1_ra_even got=%h want=%h", rd[0], {16{8'hA5}});
    end
    total++;
    if (aq[0] !== 7'd5) begin
      bad++;
      $display("FAIL t1_addr_q got=%h want=05", aq[0]);
    end
  endtask

  task automatic test_bypass();
    set_pkts(idle_pkt(), mkpkt(1'b1, 7'd9, 128'h1234));
    set_addrs(7'd0, 7'd0, 7'd0, 7'd0, 7'd9, 7'd0);
    step();
    total++;
    if (rd[4] !== 128'h1234) begin
      bad++;
      $display("FAIL t2_bypass_odd got=%h want=1234", rd[4]);
    end
    set_pkts(mkpkt(1'b1, 7'd30, 128'h77), idle_pkt());
    set_addrs(7'd0, 7'd0, 7'd0, 7'd30, 7'd9, 7'd0);
    step();
    total++;
    if (rd[4] !== 128'h1234) begin
      bad++;
      $display("FAIL t2_array_r9 got=%h want=1234", rd[4]);
    end
    total++;
    if (rd[3] !== 128'h77) begin
      bad++;
      $display("FAIL bypass_even_to_odd_port got=%h want=77", rd[3]);
    end
  endtask

  task automatic test_collision();
    set_pkts(mkpkt(1'b1, 7'd20, 128'h1), mkpkt(1'b1, 7'd20, 128'h2));
    set_addrs(7'd0, 7'd0, 7'd20, 7'd0, 7'd0, 7'd0);
    step();
    total++;
    if (rd[2] !== 128'h2) begin
      bad++;
      $display("FAIL t3_collision_bypass got=%h want=2", rd[2]);
    end
    set_pkts(idle_pkt(), idle_pkt());
    set_addrs(7'd0, 7'd0, 7'd20, 7'd20, 7'd0, 7'd0);
    step();
    total++;
    if (rd[2] !== 128'h2) begin
      bad++;
      $display("FAIL t3_collision_array got=%h want=2", rd[2]);
    end
    total++;
    if (rd[3] !== 128'h2) begin
      bad++;
      $display("FAIL t3_collision_array_odd got=%h want=2", rd[3]);
    end
  endtask

  task automatic test_we_zero();
    set_pkts(mkpkt(1'b1, 7'd7, 128'h55), idle_pkt());
    set_addrs(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    step();
    set_pkts(mkpkt(1'b0, 7'd7, 128'hFF), mkpkt(1'b0, 7'd7, 128'hFF));
    set_addrs(7'd7, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    step();
    total++;
    if (rd[0] !== 128'h55) begin
      bad++;
      $display("FAIL t4_we0_no_bypass got=%h want=55", rd[0]);
    end
    set_pkts(idle_pkt(), idle_pkt());
    step();
    total++;
    if (rd[0] !== 128'h55) begin
      bad++;
      $display("FAIL t4_we0_no_write got=%h want=55", rd[0]);
    end
  endtask

  task automatic test_boundary_regs();
    logic [127:0] v127;
    logic [127:0] v0;
    logic [6:0]   a [6];
    v127 = {4{32'h7F7F_0127}};
    v0   = {4{32'h0000_C0DE}};
    a[0] = 7'd0;   a[1] = 7'd127; a[2] = 7'd0;
    a[3] = 7'd127; a[4] = 7'd127; a[5] = 7'd0;
    set_pkts(mkpkt(1'b1, 7'd127, v127), mkpkt(1'b1, 7'd0, v0));
    set_addrs(7'd1, 7'd1, 7'd1, 7'd1, 7'd1, 7'd1);
    step();
    set_pkts(idle_pkt(), idle_pkt());
    set_addrs(a[0], a[1], a[2], a[3], a[4], a[5]);
    step();
    for (int p = 0; p < 6; p++) begin
      total++;
      if (rd[p] !== ((a[p] == 7'd127) ? v127 : v0)) begin
        bad++;
        $display("FAIL t5_data[%0d] got=%h want=%h", p, rd[p],
                 (a[p] == 7'd127) ? v127 : v0);
      end
      total++;
      if (aq[p] !== a[p]) begin
        bad++;
        $display("FAIL t5_addr_q[%0d] got=%h want=%h", p, aq[p], a[p]);
      end
    end
  endtask

  task automatic test_async_reset();
    set_pkts(mkpkt(1'b1, 7'd1, 128'h11), mkpkt(1'b1, 7'd2, 128'h22));
    set_addrs(7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    step();
    set_pkts(mkpkt(1'b1, 7'd3, 128'h33), idle_pkt());
    step();
    set_pkts(idle_pkt(), idle_pkt());
    set_addrs(7'd1, 7'd2, 7'd3, 7'd1, 7'd2, 7'd3);
    step();
    total++;
    if (rd[2] !== 128'h33) begin
      bad++;
      $display("FAIL t6_prefill got=%h want=33", rd[2]);
    end
    #2 reset = 1'b0;
    #1;
    for (int p = 0; p < 6; p++) begin
      total++;
      if (rd[p] !== 128'h0 || aq[p] !== 7'h0) begin
        bad++;
        $display("FAIL t6_async_clear[%0d] got=%h/%h want=0/0", p, rd[p], aq[p]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int p = 0; p < 6; p++) begin
      total++;
      if (rd[p] !== 128'h0) begin
        bad++;
        $display("FAIL t6_regs_cleared[%0d] got=%h want=0", p, rd[p]);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_we_zero();
    test_boundary_regs();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
